lif_neuron: RTL and testbench

Single leaky integrate-and-fire (LIF) neuron with subtractive reset, in signed fixed-point Q2.(ACC_BITS-2). Each enabled clock it decays the stored membrane by BETA, adds the weighted input current, subtracts THRESHOLD if the neuron was above threshold, saturates, and registers the new membrane and spike. It sits behind the network's per-output weighted-sum accumulator; one instance per output neuron.

---
 rtl/lif_neuron_if.sv | 13 +
 rtl/lif_neuron.sv | 60 ++++++
 tb/tb_lif_neuron.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/lif_neuron_if.sv
// Bus between the weighted-sum accumulator and one LIF output neuron.
// The master drives the enable and input current; the slave returns membrane and spike.
interface lif_neuron_if #(
  parameter int unsigned ACC_BITS = 8
) ();
  logic                       en;
  logic signed [ACC_BITS-1:0] spk_in;
  logic signed [ACC_BITS-1:0] mem_new;
  logic signed [ACC_BITS-1:0] spk_out;

  modport master (output en, output spk_in, input mem_new, input spk_out);
  modport slave  (input en, input spk_in, output mem_new, output spk_out);
endinterface

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron with subtractive reset, signed Q2.(ACC_BITS-2).
// One registered stage: decay, integrate, subtract-on-spike, saturate.
module lif_neuron #(
  parameter int unsigned              ACC_BITS  = 8,
  parameter logic signed [ACC_BITS-1:0] BETA      = 8'sb00_111111,
  parameter logic signed [ACC_BITS-1:0] THRESHOLD = 8'sb00_010000
) (
  input  logic         clk,
  input  logic         rst,
  lif_neuron_if.slave  bus
);
  localparam int unsigned FRAC = ACC_BITS - 2;
  localparam int unsigned PW   = 2 * ACC_BITS;
  localparam int unsigned SW   = ACC_BITS + 2;

  localparam logic signed [SW-1:0]       MAX_V  = SW'((1 << (ACC_BITS - 1)) - 1);
  localparam logic signed [SW-1:0]       MIN_V  = -MAX_V - SW'(1);
  localparam logic signed [ACC_BITS-1:0] ONE_V  = ACC_BITS'(1 << FRAC);
  localparam logic signed [ACC_BITS-1:0] ZERO_V = ACC_BITS'(0);

  logic signed [ACC_BITS-1:0] m_q, s_q;
  logic signed [PW-1:0]       prod;
  logic signed [PW-1:0]       decay_full;
  logic signed [SW-1:0]       rst_sub;
  logic signed [SW-1:0]       sum;
  logic signed [ACC_BITS-1:0] next_m;
  logic                       fire;

  // Next membrane and spike from the current (pre-update) membrane
  always_comb begin
    prod       = PW'(m_q) * PW'(BETA);
    decay_full = prod >>> FRAC;
    rst_sub    = SW'(0);
    if (m_q > THRESHOLD) begin
      rst_sub = SW'(THRESHOLD);
    end
    sum = SW'(decay_full) + SW'(bus.spk_in) - rst_sub;
    if (sum > MAX_V) begin
      next_m = ACC_BITS'(MAX_V);
    end else if (sum < MIN_V) begin
      next_m = ACC_BITS'(MIN_V);
    end else begin
      next_m = ACC_BITS'(sum);
    end
    fire = (next_m > THRESHOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_q <= ZERO_V;
      s_q <= ZERO_V;
    end else if (bus.en) begin
      m_q <= next_m;
      s_q <= fire ? ONE_V : ZERO_V;
    end
  end

  assign bus.mem_new = m_q;
  assign bus.spk_out = s_q;
endmodule

// File: tb/tb_lif_neuron.sv
// Directed and randomized checks of lif_neuron against an integer LIF model.
module tb_lif_neuron;
  localparam int BETA_I = 63;
  localparam int TH_I   = 16;
  localparam int SCALE  = 64;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   mm;
  int   ss;

  lif_neuron_if #(.ACC_BITS(8)) bus ();

  lif_neuron #(.ACC_BITS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $error("FAIL timeout: simulation did not complete, observed running, expected finished");
    $fatal(1, "timeout");
  end

  // Floor-divided decay, threshold subtraction on the old membrane, clamp, fire test
  function automatic void model(input int m, input int x, output int nm, output int ns);
    int p;
    int decay;
    int sum;
    p     = m * BETA_I;
    decay = (p >= 0) ? (p / SCALE) : -((-p + SCALE - 1) / SCALE);
    sum   = decay + x - ((m > TH_I) ? TH_I : 0);
    if (sum > 127)       nm = 127;
    else if (sum < -128) nm = -128;
    else                 nm = sum;
    ns = (nm > TH_I) ? SCALE : 0;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic e, input int spk, input logic r);
    int nm;
    int ns;
    @(negedge clk);
    bus.en     = e;
    bus.spk_in = 8'(spk);
    rst        = r;
    @(posedge clk);
    if (r) begin
      mm = 0;
      ss = 0;
    end else if (e) begin
      model(mm, spk, nm, ns);
      mm = nm;
      ss = ns;
    end
    #1;
    check("model_mem", int'(bus.mem_new), mm);
    check("model_spk", int'(bus.spk_out), ss);
  endtask

  task automatic dstep(input string tag, input logic e, input int spk, input logic r,
                       input int exp_m, input int exp_s);
    step(e, spk, r);
    check({tag, "_mem"}, int'(bus.mem_new), exp_m);
    check({tag, "_spk"}, int'(bus.spk_out), exp_s);
  endtask

  initial begin
    int seq_m [5];
    int seq_s [5];
    checks     = 0;
    errors     = 0;
    mm         = 0;
    ss         = 0;
    rst        = 1'b1;
    bus.en     = 1'b0;
    bus.spk_in = '0;

    dstep("reset", 1'b0, 0, 1'b1, 0, 0);
    dstep("reset_en", 1'b1, 55, 1'b1, 0, 0);

    // Held input of 10 from zero
    seq_m = '{10, 19, 12, 21, 14};
    seq_s = '{0, 64, 0, 64, 0};
    for (int i = 0; i < 5; i++) dstep("hold10", 1'b1, 10, 1'b0, seq_m[i], seq_s[i]);

    // Floor rounding keeps -10 fixed
    dstep("neg_rst", 1'b1, 0, 1'b1, 0, 0);
    dstep("neg_in", 1'b1, -10, 1'b0, -10, 0);
    for (int i = 0; i < 4; i++) dstep("floor", 1'b1, 0, 1'b0, -10, 0);

    dstep("psat_rst", 1'b1, 0, 1'b1, 0, 0);
    for (int i = 0; i < 4; i++) dstep("psat", 1'b1, 127, 1'b0, 127, 64);

    dstep("nsat_rst", 1'b1, 0, 1'b1, 0, 0);
    for (int i = 0; i < 4; i++) dstep("nsat", 1'b1, -128, 1'b0, -128, 0);

    // Enable hold
    dstep("hold_rst", 1'b1, 0, 1'b1, 0, 0);
    dstep("hold_a", 1'b1, 10, 1'b0, 10, 0);
    dstep("hold_b", 1'b1, 10, 1'b0, 19, 64);
    for (int i = 0; i < 3; i++) dstep("en_low", 1'b0, 50, 1'b0, 19, 64);
    dstep("en_resume", 1'b1, 10, 1'b0, 12, 0);

    // Mid-operation reset at M=19
    dstep("mid_rst0", 1'b1, 0, 1'b1, 0, 0);
    dstep("mid_a", 1'b1, 10, 1'b0, 10, 0);
    dstep("mid_b", 1'b1, 10, 1'b0, 19, 64);
    dstep("mid_rst", 1'b1, 10, 1'b1, 0, 0);
    dstep("mid_rel", 1'b1, 20, 1'b0, 20, 64);

    // Equality at threshold neither fires nor subtracts
    dstep("eq_rst", 1'b1, 0, 1'b1, 0, 0);
    dstep("eq_in", 1'b1, 16, 1'b0, 16, 0);
    dstep("eq_decay", 1'b1, 0, 1'b0, 15, 0);

    // Randomized stream against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0,
           int'($urandom_range(0, 255)) - 128,
           ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
